seq_divider: RTL

- Multi-cycle iterative integer divider that answers the `div_begin`/`div_end` handshake issued by the execute stage for DIV/DIVU.
- Radix-2 restoring algorithm: one quotient bit per cycle on operand magnitudes, with a final sign-fix cycle.
- Produces a 32-bit quotient (written to LO) and remainder (written to HI).
- Holds the results stable after completion so the stage can sample them in the `div_end` cycle.

---
 rtl/cpu_pkg.sv | 25 ++
 rtl/div_step.sv | 29 ++
 rtl/seq_divider.sv | 136 +++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions: widths, divider FSM encoding and sign helpers
// used by both the iterative divider and the multiplier.
package cpu_pkg;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

  function automatic logic [DATA_W-1:0] negate(input logic [DATA_W-1:0] x);
    return (~x) + DATA_W'(1);
  endfunction

  // Two's-complement magnitude; the most negative value maps onto itself (mod 2^DATA_W).
  function automatic logic [DATA_W-1:0] abs_val(input logic [DATA_W-1:0] x,
                                                 input logic             sign_en);
    return (sign_en && x[DATA_W-1]) ? negate(x) : x;
  endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step: shift {rem,quo} left, try subtracting
// the divisor from the widened remainder, keep the result if it did not borrow.
module div_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] rem,
  input  logic [W-1:0] quo,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] rem_next,
  output logic [W-1:0] quo_next
);

  logic [W:0] rem_shift;
  logic [W:0] trial;

  assign rem_shift = {rem, quo[W-1]};
  assign trial     = rem_shift - {1'b0, divisor};

  always_comb begin
    if (!trial[W]) begin
      rem_next = trial[W-1:0];
      quo_next = {quo[W-2:0], 1'b1};
    end else begin
      rem_next = rem_shift[W-1:0];
      quo_next = {quo[W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Iterative signed/unsigned divider for DIV/DIVU (quotient -> LO, remainder -> HI).
// Define SEQ_DIVIDER_ZERO_FAST_EN to short-circuit division by zero straight to FIX.
module seq_divider #(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int CNT_W  = cpu_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              div_begin,
  input  logic              div_sign,
  input  logic [DATA_W-1:0] div_op1,
  input  logic [DATA_W-1:0] div_op2,
  output logic [DATA_W-1:0] div_result,
  output logic [DATA_W-1:0] div_remainder,
  output logic              div_end
);

  import cpu_pkg::*;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  div_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rem_q, rem_d;
  logic [DATA_W-1:0] quo_q, quo_d;
  logic [DATA_W-1:0] dvs_q, dvs_d;
  logic              qsign_q, qsign_d;
  logic              rsign_q, rsign_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [DATA_W-1:0] remainder_q, remainder_d;

  logic [DATA_W-1:0] step_rem;
  logic [DATA_W-1:0] step_quo;
  logic              zero_fast;

`ifdef SEQ_DIVIDER_ZERO_FAST_EN
  assign zero_fast = (div_op2 == '0);
`else
  assign zero_fast = 1'b0;
`endif

  div_step #(.W(DATA_W)) u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .divisor  (dvs_q),
    .rem_next (step_rem),
    .quo_next (step_quo)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (div_begin) state_d = zero_fast ? FIX : BUSY;
      BUSY:    if (cnt_q == LAST_CNT) state_d = FIX;
      FIX:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    div_end = (state_q == DONE);
  end

  always_comb begin
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    qsign_d     = qsign_q;
    rsign_d     = rsign_q;
    result_d    = result_q;
    remainder_d = remainder_q;
    case (state_q)
      IDLE: begin
        if (div_begin) begin
          // The dividend magnitude enters through the quotient register and shifts out into rem.
          quo_d   = abs_val(div_op1, div_sign);
          dvs_d   = abs_val(div_op2, div_sign);
          rem_d   = '0;
          qsign_d = div_sign & (div_op1[DATA_W-1] ^ div_op2[DATA_W-1]);
          rsign_d = div_sign & div_op1[DATA_W-1];
          cnt_d   = '0;
          if (zero_fast) begin
            quo_d = '1;
            rem_d = abs_val(div_op1, div_sign);
          end
        end
      end
      BUSY: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q + CNT_W'(1);
      end
      FIX: begin
        result_d    = qsign_q ? negate(quo_q) : quo_q;
        remainder_d = rsign_q ? negate(rem_q) : rem_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      qsign_q     <= 1'b0;
      rsign_q     <= 1'b0;
      result_q    <= '0;
      remainder_q <= '0;
    end else begin
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      qsign_q     <= qsign_d;
      rsign_q     <= rsign_d;
      result_q    <= result_d;
      remainder_q <= remainder_d;
    end
  end

  assign div_result    = result_q;
  assign div_remainder = remainder_q;

endmodule
